// File: rtl/bound_flasher_pkg.sv
// bound_flasher_pkg
// Shared definitions for the bound flasher:
//   flasher_state_t - sequencer states (one per leg of the lamp pattern)
//   LVL_W           - width of a lamp level able to hold 0..MAX_LAMPS
//   therm()         - lamp level L -> thermometer vector (1<<L)-1
package bound_flasher_pkg;

    localparam int MAX_LAMPS = 64;
    localparam int LVL_W     = 7;

    typedef enum logic [3:0] {
        S_IDLE,
        S_UP_B0,
        S_DN_0,
        S_UP_B1,
        S_DN_B0,
        S_UP_TOP,
        S_DN_ALL,
        S_BLINK_ON,
        S_BLINK_OFF
    } flasher_state_t;

    // Full-width thermometer; callers truncate to their own lamp count.
    function automatic logic [MAX_LAMPS-1:0] therm(input logic [LVL_W-1:0] lvl);
        if (lvl >= LVL_W'(MAX_LAMPS)) begin
            return '1;
        end
        return (64'd1 << lvl) - 64'd1;
    endfunction

endpackage

// File: rtl/bound_flasher_tick.sv
// bound_flasher_tick
// Step prescaler: counts 0..TICK_DIV-1 and raises tick (combinationally)
// while the count sits at TICK_DIV-1, then wraps.
//   clk  - clock
//   rst  - asynchronous active-high reset, count -> 0
//   clr  - synchronous clear, count -> 0 on the next edge
//   tick - high for the one cycle whose closing edge completes a step
// TICK_DIV=1 keeps the count at zero, so tick is high every cycle.
module bound_flasher_tick #(
    parameter int TICK_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bound_flasher_param.sv
// bound_flasher_param
// Thermometer lamp sequencer. A flick in IDLE starts the pattern
//   0 -> B0+1 -> 0 -> B1+1 -> B0+1 -> NUM_LAMPS -> 0 -> blink on -> blink off
// moving the lamp level by one per prescaler tick. A flick sampled on a tick
// at the kickback points (L = B0+1 or B1+1 while climbing to B1+1, L = B1+1
// while climbing to the top) turns the climb back into the preceding descent.
//   clk   - clock, all state changes on the rising edge
//   rst   - asynchronous active-high reset
//   flick - start / kickback request, level-sampled
//   lamps - registered thermometer output (all ones during blink-on)
//   busy  - registered, high whenever the sequencer is not idle
//   done  - registered one-cycle pulse when the sequence returns to idle
module bound_flasher_param
    import bound_flasher_pkg::*;
#(
    parameter int NUM_LAMPS = 16,
    parameter int TICK_DIV  = 100,
    parameter int B0        = 5,
    parameter int B1        = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flick,
    output logic [NUM_LAMPS-1:0] lamps,
    output logic                 busy,
    output logic                 done
);

    // Elaboration-time parameter checks.
    if (NUM_LAMPS < 4 || NUM_LAMPS > MAX_LAMPS) begin : g_bad_num_lamps
        $fatal(1, "bound_flasher_param: NUM_LAMPS=%0d outside 4..64", NUM_LAMPS);
    end
    if (TICK_DIV < 1 || TICK_DIV > (1 << 20)) begin : g_bad_tick_div
        $fatal(1, "bound_flasher_param: TICK_DIV=%0d outside 1..2^20", TICK_DIV);
    end
    if (B0 < 1 || B0 >= B1 || B1 >= NUM_LAMPS - 1) begin : g_bad_bounds
        $fatal(1, "bound_flasher_param: need 1 <= B0 < B1 < NUM_LAMPS-1 (B0=%0d B1=%0d)", B0, B1);
    end

    localparam int LW = $clog2(NUM_LAMPS + 1);

    // Level values compared against the level *before* a step is applied.
    localparam logic [LW-1:0] L_ONE   = LW'(1);
    localparam logic [LW-1:0] L_B0    = LW'(B0);
    localparam logic [LW-1:0] L_B0P1  = LW'(B0 + 1);
    localparam logic [LW-1:0] L_B0P2  = LW'(B0 + 2);
    localparam logic [LW-1:0] L_B1    = LW'(B1);
    localparam logic [LW-1:0] L_B1P1  = LW'(B1 + 1);
    localparam logic [LW-1:0] L_TOPM1 = LW'(NUM_LAMPS - 1);

    flasher_state_t        state, state_n;
    logic [LW-1:0]         lvl, lvl_n;
    logic [NUM_LAMPS-1:0]  lamps_n;
    logic                  tick;
    logic                  clr;

    // Holding the prescaler clear while idle means it always starts from
    // zero on the cycle after a start flick is accepted.
    assign clr = (state == S_IDLE);

    bound_flasher_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            lvl   <= '0;
            lamps <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            lvl   <= lvl_n;
            lamps <= lamps_n;
            busy  <= (state_n != S_IDLE);
            done  <= (state == S_BLINK_OFF) && tick;
        end
    end

    // Each leg's exit test looks at the level before the step, so the state
    // changes on the same tick that the level reaches the leg's bound.
    always_comb begin
        state_n = state;
        lvl_n   = lvl;
        unique case (state)
            S_IDLE: begin
                if (flick) begin
                    state_n = S_UP_B0;
                end
            end
            S_UP_B0: begin
                if (tick) begin
                    lvl_n = lvl + 1'b1;
                    if (lvl == L_B0) begin
                        state_n = S_DN_0;
                    end
                end
            end
            S_DN_0: begin
                if (tick) begin
                    lvl_n = lvl - 1'b1;
                    if (lvl == L_ONE) begin
                        state_n = S_UP_B1;
                    end
                end
            end
            S_UP_B1: begin
                if (tick) begin
                    // Kickback is tested first so it wins over the climb.
                    if (flick && (lvl == L_B0P1 || lvl == L_B1P1)) begin
                        lvl_n   = lvl - 1'b1;
                        state_n = S_DN_0;
                    end else begin
                        lvl_n = lvl + 1'b1;
                        if (lvl == L_B1) begin
                            state_n = S_DN_B0;
                        end
                    end
                end
            end
            S_DN_B0: begin
                if (tick) begin
                    lvl_n = lvl - 1'b1;
                    // <= so a kickback landing at B0+1 (B1 == B0+1) still exits.
                    if (lvl <= L_B0P2) begin
                        state_n = S_UP_TOP;
                    end
                end
            end
            S_UP_TOP: begin
                if (tick) begin
                    if (flick && lvl == L_B1P1) begin
                        lvl_n   = lvl - 1'b1;
                        state_n = S_DN_B0;
                    end else begin
                        lvl_n = lvl + 1'b1;
                        if (lvl == L_TOPM1) begin
                            state_n = S_DN_ALL;
                        end
                    end
                end
            end
            S_DN_ALL: begin
                if (tick) begin
                    lvl_n = lvl - 1'b1;
                    if (lvl == L_ONE) begin
                        state_n = S_BLINK_ON;
                    end
                end
            end
            S_BLINK_ON: begin
                if (tick) begin
                    state_n = S_BLINK_OFF;
                end
            end
            S_BLINK_OFF: begin
                if (tick) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                lvl_n   = '0;
            end
        endcase

        lamps_n = (state_n == S_BLINK_ON) ? '1 : NUM_LAMPS'(therm(LVL_W'(lvl_n)));
    end

endmodule
